// File: rtl/impulse_capture.sv
// Room impulse-response capture: emits one full-scale click, waits for the acoustic onset,
// then streams IMPULSE_LENGTH mic samples into the impulse BRAM for the convolver.
module impulse_capture #(
    parameter int IMPULSE_LENGTH  = 48000,
    parameter int ONSET_THRESHOLD = 2000,
    parameter int MAX_DELAY       = 4800
) (
    input  logic               audio_clk,
    input  logic               rst_in,
    input  logic               start_capture,
    input  logic               audio_trigger,
    input  logic signed [15:0] audio_in,
    output logic signed [15:0] click_out,
    output logic        [15:0] write_addr,
    output logic signed [15:0] write_data,
    output logic               write_enable,
    output logic        [15:0] delay_length,
    output logic               impulse_in_memory_complete,
    output logic               busy,
    output logic               timeout_error,
    output logic        [2:0]  state_debug
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARM        = 3'd1,
        WAIT_ONSET = 3'd2,
        RECORD     = 3'd3,
        DONE       = 3'd4,
        ERROR      = 3'd5
    } state_t;

    localparam logic [15:0] LAST_ADDR = 16'(IMPULSE_LENGTH - 1);
    localparam logic [15:0] THRESH    = 16'(ONSET_THRESHOLD);
    localparam logic [15:0] MAX_CNT   = 16'(MAX_DELAY);

    state_t      state;
    logic [15:0] sample_cnt;
    logic [15:0] cnt_next;
    logic [15:0] neg_val;
    logic [14:0] mag;
    logic        onset;

    // -32768 has no positive twin in 16 bits, so its magnitude saturates to 32767.
    always_comb begin
        neg_val  = 16'(-audio_in);
        mag      = audio_in[14:0];
        if (audio_in == 16'sh8000) begin
            mag = 15'h7FFF;
        end else if (audio_in[15]) begin
            mag = neg_val[14:0];
        end
        onset    = ({1'b0, mag} >= THRESH);
        cnt_next = sample_cnt + 16'd1;
    end

    assign state_debug = state;

    // BRAM port: write_enable is a one-cycle strobe; write_addr/write_data are valid while it is
    // high and hold their last values otherwise. The BRAM is always ready (no back-pressure).
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state                      <= IDLE;
            sample_cnt                 <= '0;
            click_out                  <= '0;
            write_addr                 <= '0;
            write_data                 <= '0;
            write_enable               <= 1'b0;
            delay_length               <= '0;
            impulse_in_memory_complete <= 1'b0;
            busy                       <= 1'b0;
            timeout_error              <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            if (audio_trigger) begin
                click_out <= '0;
            end
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_capture) begin
                        state                      <= ARM;
                        busy                       <= 1'b1;
                        delay_length               <= '0;
                        impulse_in_memory_complete <= 1'b0;
                        timeout_error              <= 1'b0;
                    end
                end
                ARM: begin
                    if (audio_trigger) begin
                        click_out  <= 16'sh7FFF;
                        sample_cnt <= '0;
                        state      <= WAIT_ONSET;
                    end
                end
                WAIT_ONSET: begin
                    if (audio_trigger) begin
                        sample_cnt <= cnt_next;
                        if (onset) begin
                            delay_length <= cnt_next;
                            write_addr   <= '0;
                            write_data   <= audio_in;
                            write_enable <= 1'b1;
                            if (LAST_ADDR == 16'd0) begin
                                state                      <= DONE;
                                impulse_in_memory_complete <= 1'b1;
                                busy                       <= 1'b0;
                            end else begin
                                state <= RECORD;
                            end
                        end else if (cnt_next == MAX_CNT) begin
                            state         <= ERROR;
                            timeout_error <= 1'b1;
                            busy          <= 1'b0;
                        end
                    end
                end
                RECORD: begin
                    if (audio_trigger) begin
                        write_addr   <= write_addr + 16'd1;
                        write_data   <= audio_in;
                        write_enable <= 1'b1;
                        if (write_addr + 16'd1 == LAST_ADDR) begin
                            state                      <= DONE;
                            impulse_in_memory_complete <= 1'b1;
                            busy                       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_impulse_capture.sv
// Directed bench for impulse_capture: BRAM writes go through an expected-write queue checked by
// a negedge monitor; control outputs are compared directly after each sample.
module tb_impulse_capture;

    localparam int IL = 1200;
    localparam int MD = 4800;

    logic        audio_clk;
    logic        rst_in;
    logic        start_capture;
    logic        audio_trigger;
    logic [15:0] audio_in;
    logic [15:0] click_out;
    logic [15:0] write_addr;
    logic [15:0] write_data;
    logic        write_enable;
    logic [15:0] delay_length;
    logic        impulse_in_memory_complete;
    logic        busy;
    logic        timeout_error;
    logic [2:0]  state_debug;

    logic [31:0] exp_q[$];
    int          checks;
    int          errors;
    int          write_count;
    logic [15:0] last_addr;

    impulse_capture #(
        .IMPULSE_LENGTH (IL),
        .ONSET_THRESHOLD(2000),
        .MAX_DELAY      (MD)
    ) dut (
        .audio_clk                 (audio_clk),
        .rst_in                    (rst_in),
        .start_capture             (start_capture),
        .audio_trigger             (audio_trigger),
        .audio_in                  (audio_in),
        .click_out                 (click_out),
        .write_addr                (write_addr),
        .write_data                (write_data),
        .write_enable              (write_enable),
        .delay_length              (delay_length),
        .impulse_in_memory_complete(impulse_in_memory_complete),
        .busy                      (busy),
        .timeout_error             (timeout_error),
        .state_debug               (state_debug)
    );

    // clock / reset
    initial audio_clk = 1'b0;
    always #5 audio_clk = ~audio_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst_in = 1'b1;
        @(posedge audio_clk); #1;
        @(posedge audio_clk); #1;
        rst_in = 1'b0;
    endtask

    // drivers
    task automatic send_sample(input logic [15:0] s);
        audio_in      = s;
        audio_trigger = 1'b1;
        @(posedge audio_clk); #1;
        audio_trigger = 1'b0;
        audio_in      = 16'h0000;
        @(posedge audio_clk); #1;
    endtask

    task automatic pulse_start();
        start_capture = 1'b1;
        @(posedge audio_clk); #1;
        start_capture = 1'b0;
    endtask

    task automatic expect_write(input int addr, input logic [15:0] data);
        exp_q.push_back({16'(addr), data});
    endtask

    function automatic logic [15:0] rec_data(input int i);
        return 16'((i * 53) ^ 16'hA5A5);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_click"}, 32'(click_out), 32'h0);
        check({tag, "_waddr"}, 32'(write_addr), 32'h0);
        check({tag, "_wdata"}, 32'(write_data), 32'h0);
        check({tag, "_we"}, 32'(write_enable), 32'h0);
        check({tag, "_delay"}, 32'(delay_length), 32'h0);
        check({tag, "_complete"}, 32'(impulse_in_memory_complete), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_timeout"}, 32'(timeout_error), 32'h0);
        check({tag, "_state"}, 32'(state_debug), 32'h0);
    endtask

    // scoreboard monitor
    always @(negedge audio_clk) begin
        if (write_enable === 1'b1) begin
            logic [31:0] exp_w;
            write_count++;
            last_addr = write_addr;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         write_addr, write_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({write_addr, write_data} !== exp_w) begin
                    errors++;
                    $display("FAIL bram_write: got addr %0h data %0h expected addr %0h data %0h",
                             write_addr, write_data, exp_w[31:16], exp_w[15:0]);
                end
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        write_count   = 0;
        last_addr     = '0;
        rst_in        = 1'b0;
        start_capture = 1'b0;
        audio_trigger = 1'b0;
        audio_in      = 16'h0000;

        // Onset at 100 samples after the click
        apply_reset();
        check_all_zero("reset");
        pulse_start();
        check("arm_busy", 32'(busy), 32'h1);
        check("arm_state", 32'(state_debug), 32'h1);
        send_sample(16'h1234);
        check("click_on", 32'(click_out), 32'h7FFF);
        check("click_delay0", 32'(delay_length), 32'h0);
        for (int n = 1; n <= 99; n++) begin
            send_sample(16'h0000);
            if (n == 1) check("click_off", 32'(click_out), 32'h0);
        end
        check("pre_onset_writes", 32'(write_count), 32'h0);
        expect_write(0, 16'd2500);
        send_sample(16'd2500);
        check("delay_100", 32'(delay_length), 32'd100);
        check("rec_busy", 32'(busy), 32'h1);
        for (int a = 1; a < IL; a++) begin
            expect_write(a, rec_data(a));
            send_sample(rec_data(a));
        end
        check("done_complete", 32'(impulse_in_memory_complete), 32'h1);
        check("done_busy", 32'(busy), 32'h0);
        check("done_state", 32'(state_debug), 32'h4);
        check("done_writes", 32'(write_count), 32'(IL));
        check("done_last_addr", 32'(last_addr), 32'(IL - 1));
        check("done_delay", 32'(delay_length), 32'd100);
        for (int n = 0; n < 3; n++) send_sample(16'h7000);
        check("done_no_more_writes", 32'(write_count), 32'(IL));
        check("done_held", 32'(impulse_in_memory_complete), 32'h1);

        // Restart after DONE; -1999 misses, -2000 hits at 37; second start in RECORD ignored
        pulse_start();
        check("restart_complete", 32'(impulse_in_memory_complete), 32'h0);
        check("restart_delay", 32'(delay_length), 32'h0);
        check("restart_busy", 32'(busy), 32'h1);
        send_sample(16'h0000);
        for (int n = 1; n <= 35; n++) send_sample(16'h0000);
        send_sample(16'hF831);
        check("neg_1999_no_onset", 32'(delay_length), 32'h0);
        check("neg_1999_state", 32'(state_debug), 32'h2);
        expect_write(0, 16'hF830);
        send_sample(16'hF830);
        check("delay_37", 32'(delay_length), 32'd37);
        for (int a = 1; a < IL; a++) begin
            expect_write(a, rec_data(a + 7));
            send_sample(rec_data(a + 7));
            if (a == 500) begin
                pulse_start();
                check("ignore_busy", 32'(busy), 32'h1);
                check("ignore_state", 32'(state_debug), 32'h3);
                check("ignore_delay", 32'(delay_length), 32'd37);
            end
        end
        check("run2_complete", 32'(impulse_in_memory_complete), 32'h1);
        check("run2_writes", 32'(write_count), 32'(2 * IL));
        check("run2_last_addr", 32'(last_addr), 32'(IL - 1));

        // -32768 on the first sample qualifies; reset mid-record at addr 1000
        pulse_start();
        send_sample(16'h0000);
        expect_write(0, 16'h8000);
        send_sample(16'h8000);
        check("delay_1_sat", 32'(delay_length), 32'd1);
        for (int a = 1; a <= 1000; a++) begin
            expect_write(a, rec_data(a + 3));
            send_sample(rec_data(a + 3));
        end
        check("pre_reset_addr", 32'(last_addr), 32'd1000);
        rst_in = 1'b1;
        @(posedge audio_clk); #1;
        rst_in = 1'b0;
        check_all_zero("midrec_reset");
        for (int n = 0; n < 5; n++) send_sample(16'h4000);
        check("reset_no_writes", 32'(write_count), 32'(2 * IL + 1001));
        check("reset_complete", 32'(impulse_in_memory_complete), 32'h0);

        // Timeout: no onset within MAX_DELAY samples
        pulse_start();
        send_sample(16'h0000);
        for (int n = 1; n < MD; n++) send_sample((n == 10) ? 16'd1999 : 16'h0000);
        check("pre_timeout_flag", 32'(timeout_error), 32'h0);
        check("pre_timeout_busy", 32'(busy), 32'h1);
        send_sample(16'h0000);
        check("timeout_flag", 32'(timeout_error), 32'h1);
        check("timeout_busy", 32'(busy), 32'h0);
        check("timeout_state", 32'(state_debug), 32'h5);
        check("timeout_delay", 32'(delay_length), 32'h0);
        check("timeout_writes", 32'(write_count), 32'(2 * IL + 1001));
        pulse_start();
        check("rearm_timeout_clr", 32'(timeout_error), 32'h0);
        check("rearm_busy", 32'(busy), 32'h1);
        check("rearm_state", 32'(state_debug), 32'h1);

        check("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
